onehot_decoder_seq: RTL

- Registered, parametrised successor to the combinational decoder2/4/8 family: decodes an SEL_W-bit select into a 2**SEL_W one-hot output vector.
- Commands arrive through a valid/ready handshake, with four modes: timed pulse, hold, scan (walk across consecutive outputs) and clear.
- Used wherever the design must drive strobes or chip-selects with defined timing, not static combinational decode.

---
 rtl/onehot_decoder_seq_if.sv | 26 ++
 rtl/onehot_decoder_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq_if.sv
// Command/decode bundle for onehot_decoder_seq: handshake inputs plus registered decode outputs.
interface onehot_decoder_seq_if #(
  parameter int unsigned SEL_W = 3
);
  localparam int unsigned N = 2 ** SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [1:0]       in_mode;
  logic [SEL_W-1:0] in_count;
  logic [N-1:0]     out_onehot;
  logic [SEL_W-1:0] out_index;
  logic             out_valid;
  logic             done;

  modport master (
    output in_valid, in_sel, in_mode, in_count,
    input  in_ready, out_onehot, out_index, out_valid, done
  );

  modport slave (
    input  in_valid, in_sel, in_mode, in_count,
    output in_ready, out_onehot, out_index, out_valid, done
  );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with PULSE / HOLD / SCAN / CLEAR commands over a valid/ready handshake.
module onehot_decoder_seq #(
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned PULSE_LEN = 1
) (
  input logic                clk,
  input logic                rst,
  onehot_decoder_seq_if.slave bus
);
  localparam int unsigned N     = 2 ** SEL_W;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] MODE_PULSE = 2'b00;
  localparam logic [1:0] MODE_HOLD  = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD, SCAN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] steps, steps_nxt;
  logic [SEL_W-1:0] index, index_nxt;
  logic             active, active_nxt;
  logic             done_q, done_nxt;
  logic [N-1:0]     onehot;
  logic             accept;

  assign bus.in_ready   = !rst && (state == IDLE || state == HOLD);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_onehot = onehot;
  assign bus.out_index  = index;
  assign bus.out_valid  = active;
  assign bus.done       = done_q;

  // Next state and next registered outputs; done_nxt flags the last active cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    steps_nxt  = steps;
    index_nxt  = index;
    active_nxt = active;
    done_nxt   = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          case (bus.in_mode)
            MODE_PULSE: begin
              state_nxt  = PULSE;
              index_nxt  = bus.in_sel;
              active_nxt = 1'b1;
              cnt_nxt    = CNT_W'(PULSE_LEN - 1);
              done_nxt   = (PULSE_LEN == 32'd1);
            end
            MODE_HOLD: begin
              state_nxt  = HOLD;
              index_nxt  = bus.in_sel;
              active_nxt = 1'b1;
            end
            MODE_SCAN: begin
              state_nxt  = SCAN;
              index_nxt  = bus.in_sel;
              active_nxt = 1'b1;
              steps_nxt  = bus.in_count;
              done_nxt   = (bus.in_count == '0);
            end
            default: begin
              state_nxt  = IDLE;
              index_nxt  = '0;
              active_nxt = 1'b0;
            end
          endcase
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt  = IDLE;
          index_nxt  = '0;
          active_nxt = 1'b0;
        end else begin
          cnt_nxt  = cnt - CNT_W'(1);
          done_nxt = (cnt == CNT_W'(1));
        end
      end
      SCAN: begin
        if (steps == '0) begin
          state_nxt  = IDLE;
          index_nxt  = '0;
          active_nxt = 1'b0;
        end else begin
          // SEL_W-bit add wraps N-1 back to 0
          index_nxt = index + SEL_W'(1);
          steps_nxt = steps - SEL_W'(1);
          done_nxt  = (steps == SEL_W'(1));
        end
      end
      default: begin
        state_nxt  = IDLE;
        index_nxt  = '0;
        active_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      steps  <= '0;
      index  <= '0;
      active <= 1'b0;
      done_q <= 1'b0;
      onehot <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      steps  <= steps_nxt;
      index  <= index_nxt;
      active <= active_nxt;
      done_q <= done_nxt;
      onehot <= active_nxt ? (N'(1) << index_nxt) : '0;
    end
  end
endmodule
